sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single SRAM controller between NUM_REQ requesters: port 0 = VGA frame fetch (real-time), remaining ports = sprite/game-logic masters.
- Accepts one transaction at a time and sequences the controller's ready/write_en/addr/data_w handshake, then returns completion and read data to the owner.
- Arbitration: fixed priority for port 0; round-robin among ports 1..NUM_REQ-1; anti-starvation override; timeout watchdog.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- STARVE_LIMIT, 16, cycles a pending non-zero port may wait before it outranks port 0
- TIMEOUT, 8, cycles allowed in WAIT for mem_done before abort

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-port request; held until req_gnt
- req_we  in  NUM_REQ  per-port 1=write, 0=read
- req_addr  in  NUM_REQ*20  per-port address, port i at [20i+19:20i]
- req_wdata  in  NUM_REQ*16  per-port write data, port i at [16i+15:16i]
- req_gnt  out  NUM_REQ  one-hot one-cycle pulse: request accepted, inputs sampled
- req_done  out  NUM_REQ  one-hot one-cycle pulse: transaction complete
- rdata  out  16  read data, valid in the req_done cycle of a read
- mem_ready  out  1  to controller ready
- mem_write_en  out  1  to controller write_en
- mem_addr  out  20  to controller addr
- mem_wdata  out  16  to controller data_w
- mem_done  in  1  from controller done
- mem_rdata  in  16  from controller data
- timeout_err  out  1  sticky: a transaction timed out

Behaviour:
- Reset (async, Reset_n=0): state IDLE, all outputs 0, rr pointer = 1, starvation counters 0, timeout_err 0. Reset mid-transaction abandons it; no req_done.
- All outputs registered.
- States: IDLE, ISSUE, WAIT.
- IDLE: if any req_valid and mem_done=1, pick winner, pulse req_gnt[w], latch we/addr/wdata, go ISSUE. If mem_done=0, stay.
- Winner order:
  1. Starved port: lowest-index non-zero port whose counter = STARVE_LIMIT.
  2. Else port 0 if valid.
  3. Else first valid port at or after rr pointer, cyclic over 1..NUM_REQ-1.
- rr pointer moves to winner+1 (wrapping NUM_REQ-1 to 1) only on a round-robin or starvation grant.
- ISSUE (1 cycle): mem_ready=1, mem_write_en/addr/wdata = latched values; go WAIT, clear watchdog.
- WAIT: mem_ready=0. Watchdog counts each WAIT cycle.
  - Write: complete on first WAIT cycle with mem_done=1; nominally the cycle after ISSUE.
  - Read: complete on first mem_done=1 after mem_done was seen 0 in WAIT; nominally 2 cycles after ISSUE.
  - On completion: register mem_rdata into rdata (reads only; rdata holds otherwise), pulse req_done[owner], go IDLE.
  - Watchdog = TIMEOUT: set timeout_err, pulse req_done[owner] (rdata unchanged), go IDLE.
- Minimum per-transaction cost: write 3 cycles, read 4 cycles (IDLE→ISSUE→WAIT(s)→IDLE).
- Starvation counter per port 1..NUM_REQ-1:
  - increments each cycle req_valid=1 and not granted, saturating at STARVE_LIMIT;
  - clears on that port's grant or when req_valid=0.
- Port 0 has no counter.
- A requester may raise req_valid in the same cycle it sees req_done; it is eligible in the next IDLE.
- Dropping req_valid before grant withdraws the request.
- Inputs are ignored between grant and done.
- timeout_err clears only on reset.

Decomposition:
- Shared package sram_pkg:
  - SRAM_AW=20, SRAM_DW=16
  - arb_state_t enum {IDLE, ISSUE, WAIT}
  - width function for port index: $clog2(NUM_REQ)
- One natural sub-module: sram_rr_pick, a combinational round-robin picker taking the valid vector and pointer and returning the winner index and a found flag.
- Starvation logic and FSM remain in the top.

Test Plan:
- Single read: port 1 reads 0x00123, model returns 0xBEEF → mem_ready pulse with addr=0x00123, we=0; req_done[1] 4 cycles after gnt; rdata=0xBEEF.
- Single write: port 2 writes 0xA5A5 to 0xFFFFF → mem_write_en=1, mem_wdata=0xA5A5; req_done[2] 2 cycles after gnt; rdata unchanged.
- Priority + round-robin: ports 0,1,2 all valid continuously → grants 0,0,0… until port 1 counter reaches 16, then grant 1; port 0 next, then port 2 at its limit; rr pointer alternates 1/2.
- Contention without port 0: ports 1,2 held valid, 6 reads → grants 1,2,1,2,1,2.
- Timeout: model holds mem_done=0 after a read issue → after 8 WAIT cycles, timeout_err=1, req_done pulses, next request serviced normally.
- Async reset mid-WAIT: Reset_n low between clock edges → all outputs 0 immediately, no req_done, IDLE after release.

Source files
------------

// File: rtl/sram_pkg.sv
// rtl/sram_pkg.sv - shared widths, arbiter state type and index-width helper
package sram_pkg;
  localparam int SRAM_AW = 20;
  localparam int SRAM_DW = 16;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} arb_state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/sram_rr_pick.sv
// rtl/sram_rr_pick.sv - combinational round-robin picker over ports 1..NUM_REQ-1
module sram_rr_pick import sram_pkg::*; #(
  parameter int NUM_REQ = 3,
  parameter int IW      = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:1] valid,
  input  logic [IW-1:0]      ptr,
  output logic [IW-1:0]      idx,
  output logic               found
);
  int cand;

  // Scan starting at ptr, wrapping NUM_REQ-1 back to 1; port 0 never participates.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 1;
    for (int off = 0; off < NUM_REQ - 1; off++) begin
      cand = ((int'(ptr) - 1 + off) % (NUM_REQ - 1)) + 1;
      if (!found && valid[cand]) begin
        found = 1'b1;
        idx   = IW'(cand);
      end
    end
  end
endmodule

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - shares one SRAM controller between NUM_REQ requesters
module sram_arbiter import sram_pkg::*; #(
  parameter int NUM_REQ      = 3,
  parameter int STARVE_LIMIT = 16,
  parameter int TIMEOUT      = 8
) (
  input  logic                       Clk,
  input  logic                       Reset_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_we,
  input  logic [NUM_REQ*SRAM_AW-1:0] req_addr,
  input  logic [NUM_REQ*SRAM_DW-1:0] req_wdata,
  output logic [NUM_REQ-1:0]         req_gnt,
  output logic [NUM_REQ-1:0]         req_done,
  output logic [SRAM_DW-1:0]         rdata,
  output logic                       mem_ready,
  output logic                       mem_write_en,
  output logic [SRAM_AW-1:0]         mem_addr,
  output logic [SRAM_DW-1:0]         mem_wdata,
  input  logic                       mem_done,
  input  logic [SRAM_DW-1:0]         mem_rdata,
  output logic                       timeout_err
);
  localparam int IW = idx_w(NUM_REQ);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam int WW = $clog2(TIMEOUT + 1);

  arb_state_t    state, state_nx;
  logic [IW-1:0] rr_ptr, rr_idx, owner, win, starve_idx;
  logic          rr_found, starve_hit, win_found, win_rr;
  logic          grant_now, complete, tmo, done_ok, seen_zero;
  logic [WW-1:0] wd_cnt;
  logic [CW-1:0] starve_cnt [1:NUM_REQ-1];

  sram_rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr_pick (
    .valid (req_valid[NUM_REQ-1:1]),
    .ptr   (rr_ptr),
    .idx   (rr_idx),
    .found (rr_found)
  );

  // Descending scan so the lowest-index starved port is the one left standing.
  always_comb begin
    starve_hit = 1'b0;
    starve_idx = '0;
    for (int i = NUM_REQ - 1; i >= 1; i--) begin
      if (req_valid[i] && starve_cnt[i] == CW'(STARVE_LIMIT)) begin
        starve_hit = 1'b1;
        starve_idx = IW'(i);
      end
    end
    win_found = 1'b1;
    win_rr    = 1'b0;
    win       = '0;
    if (starve_hit) begin
      win    = starve_idx;
      win_rr = 1'b1;
    end else if (!req_valid[0]) begin
      win       = rr_idx;
      win_found = rr_found;
      win_rr    = 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Reads must see done fall before its rise counts; writes finish on the first done.
  always_comb begin
    state_nx  = state;
    grant_now = 1'b0;
    complete  = 1'b0;
    tmo       = 1'b0;
    done_ok   = mem_write_en ? mem_done : (seen_zero && mem_done);
    unique case (state)
      IDLE: begin
        if (win_found && mem_done) begin
          grant_now = 1'b1;
          state_nx  = ISSUE;
        end
      end
      ISSUE: state_nx = WAIT;
      WAIT: begin
        if (done_ok) begin
          complete = 1'b1;
          state_nx = IDLE;
        end else if (wd_cnt == WW'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      req_gnt      <= '0;
      req_done     <= '0;
      rdata        <= '0;
      mem_ready    <= 1'b0;
      mem_write_en <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      timeout_err  <= 1'b0;
      owner        <= '0;
      rr_ptr       <= IW'(1);
      wd_cnt       <= '0;
      seen_zero    <= 1'b0;
    end else begin
      req_gnt   <= '0;
      req_done  <= '0;
      mem_ready <= 1'b0;
      if (grant_now) begin
        req_gnt      <= NUM_REQ'(1) << win;
        mem_ready    <= 1'b1;
        mem_write_en <= req_we[win];
        mem_addr     <= req_addr[int'(win)*SRAM_AW +: SRAM_AW];
        mem_wdata    <= req_wdata[int'(win)*SRAM_DW +: SRAM_DW];
        owner        <= win;
        if (win_rr)
          rr_ptr <= (int'(win) == NUM_REQ - 1) ? IW'(1) : win + IW'(1);
      end
      if (state == ISSUE) begin
        wd_cnt    <= '0;
        seen_zero <= 1'b0;
      end else if (state == WAIT) begin
        wd_cnt <= wd_cnt + WW'(1);
        if (!mem_done) seen_zero <= 1'b1;
      end
      if (complete || tmo) req_done <= NUM_REQ'(1) << owner;
      if (complete && !mem_write_en) rdata <= mem_rdata;
      if (tmo) timeout_err <= 1'b1;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 1; i < NUM_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 1; i < NUM_REQ; i++) begin
        if (!req_valid[i] || (grant_now && int'(win) == i))
          starve_cnt[i] <= '0;
        else if (starve_cnt[i] != CW'(STARVE_LIMIT))
          starve_cnt[i] <= starve_cnt[i] + CW'(1);
      end
    end
  end
endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with a behavioural controller
module tb_sram_arbiter;
  localparam int N = 3;
  localparam int READ_LAT = 2;

  logic            Clk = 1'b0;
  logic            Reset_n = 1'b0;
  logic [N-1:0]    req_valid, req_we, req_gnt, req_done;
  logic [N*20-1:0] req_addr;
  logic [N*16-1:0] req_wdata;
  logic [15:0]     rdata, mem_wdata, mem_rdata;
  logic [19:0]     mem_addr;
  logic            mem_ready, mem_write_en, mem_done, timeout_err;

  int          passed = 0;
  int          total = 0;
  int          exp_port_q[$];
  logic [15:0] exp_data_q[$];
  logic [15:0] last_rdata = 16'h0000;

  sram_arbiter #(.NUM_REQ(N), .STARVE_LIMIT(16), .TIMEOUT(8)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_gnt(req_gnt), .req_done(req_done),
    .rdata(rdata), .mem_ready(mem_ready), .mem_write_en(mem_write_en), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_done(mem_done), .mem_rdata(mem_rdata), .timeout_err(timeout_err)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] model_val(input logic [19:0] a);
    if (a == 20'h00123) return 16'hBEEF;
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // Controller: writes keep done high, reads drop done for READ_LAT cycles; hang freezes done low.
  int          busy = 0;
  logic        hang = 1'b0;
  logic        hung = 1'b0;
  logic [15:0] rd_reg = 16'h0000;
  always @(posedge Clk) begin
    if (mem_ready) begin
      if (!mem_write_en) begin
        busy   <= READ_LAT;
        rd_reg <= model_val(mem_addr);
      end
      hung <= hang;
    end else begin
      if (busy > 0) busy <= busy - 1;
      hung <= hung && hang;
    end
  end
  assign mem_done  = (busy == 0) && !hung;
  assign mem_rdata = mem_done ? rd_reg : 16'hDEAD;

  task automatic set_req(input int p, input logic v, input logic we,
                         input logic [19:0] a, input logic [15:0] d);
    req_valid[p]         = v;
    req_we[p]            = we;
    req_addr[p*20 +: 20] = a;
    req_wdata[p*16 +: 16] = d;
  endtask

  task automatic wait_gnt(input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge Clk);
      if (req_gnt != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    for (int k = 1; k <= max; k++) begin
      @(negedge Clk);
      if (req_done != '0) begin
        n = k;
        break;
      end
    end
  endtask

  task automatic test_reset;
    Reset_n = 1'b0;
    repeat (3) @(negedge Clk);
    total++;
    if ({req_gnt, req_done, rdata, mem_ready, mem_write_en, mem_addr, mem_wdata, timeout_err} !== '0)
      $display("FAIL reset_outputs gnt=%b done=%b rdata=%h rdy=%b we=%b addr=%h wd=%h terr=%b required all 0",
               req_gnt, req_done, rdata, mem_ready, mem_write_en, mem_addr, mem_wdata, timeout_err);
    else passed++;
    Reset_n = 1'b1;
    repeat (2) @(negedge Clk);
    total++;
    if ({req_gnt, req_done, mem_ready} !== '0)
      $display("FAIL idle_after_reset gnt=%b done=%b rdy=%b required 0", req_gnt, req_done, mem_ready);
    else passed++;
  endtask

  task automatic test_single_read;
    int n;
    logic [15:0] ed;
    set_req(1, 1'b1, 1'b0, 20'h00123, 16'h0000);
    exp_data_q.push_back(16'hBEEF);
    wait_gnt(6, n);
    total++;
    if (req_gnt !== 3'b010 || mem_ready !== 1'b1 || mem_write_en !== 1'b0 || mem_addr !== 20'h00123)
      $display("FAIL read_issue gnt=%b rdy=%b we=%b addr=%h required 010 1 0 00123",
               req_gnt, mem_ready, mem_write_en, mem_addr);
    else passed++;
    req_valid[1] = 1'b0;
    wait_done(10, n);
    ed = exp_data_q.pop_front();
    total++;
    if (n !== 4) $display("FAIL read_latency got %0d cycles required 4", n);
    else passed++;
    total++;
    if (req_done !== 3'b010 || rdata !== ed)
      $display("FAIL read_done done=%b rdata=%h required 010 %h", req_done, rdata, ed);
    else passed++;
    last_rdata = ed;
    @(negedge Clk);
    total++;
    if (req_done !== 3'b000) $display("FAIL read_done_pulse done=%b required 000", req_done);
    else passed++;
  endtask

  task automatic test_single_write;
    int n;
    set_req(2, 1'b1, 1'b1, 20'hFFFFF, 16'hA5A5);
    wait_gnt(6, n);
    total++;
    if (req_gnt !== 3'b100 || mem_ready !== 1'b1 || mem_write_en !== 1'b1 ||
        mem_addr !== 20'hFFFFF || mem_wdata !== 16'hA5A5)
      $display("FAIL write_issue gnt=%b rdy=%b we=%b addr=%h wd=%h required 100 1 1 fffff a5a5",
               req_gnt, mem_ready, mem_write_en, mem_addr, mem_wdata);
    else passed++;
    req_valid[2] = 1'b0;
    wait_done(10, n);
    total++;
    if (n !== 2) $display("FAIL write_latency got %0d cycles required 2", n);
    else passed++;
    total++;
    if (req_done !== 3'b100 || rdata !== last_rdata)
      $display("FAIL write_done done=%b rdata=%h required 100 %h", req_done, rdata, last_rdata);
    else passed++;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_contention;
    int n, ep;
    logic [15:0] ed;
    logic [N-1:0] eg;
    set_req(1, 1'b1, 1'b0, 20'h10001, 16'h0000);
    set_req(2, 1'b1, 1'b0, 20'h20002, 16'h0000);
    for (int g = 0; g < 6; g++) begin
      exp_port_q.push_back((g % 2 == 0) ? 1 : 2);
      exp_data_q.push_back(model_val((g % 2 == 0) ? 20'h10001 : 20'h20002));
    end
    for (int g = 0; g < 6; g++) begin
      wait_gnt(8, n);
      ep = exp_port_q.pop_front();
      eg = '0;
      eg[ep] = 1'b1;
      total++;
      if (req_gnt !== eg) $display("FAIL rr_grant_%0d gnt=%b required %b", g, req_gnt, eg);
      else passed++;
      if (g == 5) begin
        req_valid[1] = 1'b0;
        req_valid[2] = 1'b0;
      end
      wait_done(8, n);
      ed = exp_data_q.pop_front();
      total++;
      if (req_done !== eg || rdata !== ed)
        $display("FAIL rr_done_%0d done=%b rdata=%h required %b %h", g, req_done, rdata, eg, ed);
      else passed++;
      last_rdata = ed;
    end
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_priority;
    int n, ep;
    logic [N-1:0] eg;
    int order [14] = '{0, 0, 0, 0, 0, 0, 1, 2, 0, 0, 0, 0, 1, 2};
    foreach (order[i]) exp_port_q.push_back(order[i]);
    set_req(0, 1'b1, 1'b1, 20'h00A00, 16'h1111);
    set_req(1, 1'b1, 1'b1, 20'h00B00, 16'h2222);
    set_req(2, 1'b1, 1'b1, 20'h00C00, 16'h3333);
    for (int g = 0; g < 14; g++) begin
      wait_gnt(6, n);
      ep = exp_port_q.pop_front();
      eg = '0;
      eg[ep] = 1'b1;
      total++;
      if (req_gnt !== eg) $display("FAIL prio_grant_%0d gnt=%b required %b", g, req_gnt, eg);
      else passed++;
    end
    req_valid = '0;
    repeat (4) @(negedge Clk);
  endtask

  task automatic test_timeout;
    int n;
    logic [15:0] ed;
    hang = 1'b1;
    set_req(1, 1'b1, 1'b0, 20'h00042, 16'h0000);
    wait_gnt(6, n);
    req_valid[1] = 1'b0;
    wait_done(15, n);
    total++;
    if (n !== 9) $display("FAIL timeout_latency got %0d cycles required 9", n);
    else passed++;
    total++;
    if (req_done !== 3'b010 || timeout_err !== 1'b1 || rdata !== last_rdata)
      $display("FAIL timeout_done done=%b terr=%b rdata=%h required 010 1 %h",
               req_done, timeout_err, rdata, last_rdata);
    else passed++;
    hang = 1'b0;
    set_req(2, 1'b1, 1'b0, 20'h00777, 16'h0000);
    exp_data_q.push_back(model_val(20'h00777));
    wait_gnt(6, n);
    total++;
    if (req_gnt !== 3'b100) $display("FAIL after_timeout_grant gnt=%b required 100", req_gnt);
    else passed++;
    req_valid[2] = 1'b0;
    wait_done(10, n);
    ed = exp_data_q.pop_front();
    total++;
    if (n !== 4 || rdata !== ed || timeout_err !== 1'b1)
      $display("FAIL after_timeout_read cycles=%0d rdata=%h terr=%b required 4 %h 1", n, rdata, timeout_err, ed);
    else passed++;
    last_rdata = ed;
    repeat (2) @(negedge Clk);
  endtask

  task automatic test_async_reset;
    int n;
    logic [N-1:0] seen;
    set_req(1, 1'b1, 1'b0, 20'h00321, 16'h0000);
    wait_gnt(6, n);
    req_valid[1] = 1'b0;
    @(negedge Clk);
    #2 Reset_n = 1'b0;
    #1;
    total++;
    if ({req_gnt, req_done, rdata, mem_ready, mem_write_en, mem_addr, mem_wdata, timeout_err} !== '0)
      $display("FAIL async_reset_outputs addr=%h rdata=%h terr=%b required all 0", mem_addr, rdata, timeout_err);
    else passed++;
    seen = '0;
    repeat (3) begin
      @(negedge Clk);
      seen |= req_done;
    end
    Reset_n = 1'b1;
    repeat (4) begin
      @(negedge Clk);
      seen |= req_done;
    end
    total++;
    if (seen !== 3'b000) $display("FAIL abandoned_done done_seen=%b required 000", seen);
    else passed++;
    set_req(2, 1'b1, 1'b1, 20'h00055, 16'h7E7E);
    wait_gnt(1, n);
    total++;
    if (req_gnt !== 3'b100 || mem_wdata !== 16'h7E7E)
      $display("FAIL post_reset_grant gnt=%b wd=%h required 100 7e7e", req_gnt, mem_wdata);
    else passed++;
    req_valid[2] = 1'b0;
    wait_done(6, n);
    total++;
    if (req_done !== 3'b100 || rdata !== 16'h0000)
      $display("FAIL post_reset_done done=%b rdata=%h required 100 0000", req_done, rdata);
    else passed++;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout simulation exceeded time bound");
    $fatal(1);
  end

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset;
    test_single_read;
    test_single_write;
    test_contention;
    test_priority;
    test_timeout;
    test_async_reset;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
